ballot_session_arbiter: RTL
===========================

Name: ballot_session_arbiter

Overview:
Shares one ballot-entry core among N_TERM keypad terminals. Grants one terminal at a time for a complete voting session: four digits, then a confirm. Forwards only the granted terminal's key strobes to the core, one registered pulse per key. Enforces an inactivity timeout and a cancel path, and reports each session's outcome upstream.

Parameters:
N_TERM, 4, number of keypad terminals (2..8)
TIMEOUT_CYCLES, 1000, idle cycles allowed between accepted events before abort (>=2)
TW, 16, width of timeout counter; must hold TIMEOUT_CYCLES-1

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
req  in  N_TERM  terminal requests a session (level)
term_valid  in  N_TERM  key strobe per terminal, one-cycle pulse
term_digit  in  4*N_TERM  BCD digit per terminal; terminal i uses bits [4i+3:4i]
term_confirm  in  N_TERM  qualifies term_valid as the confirm key
term_cancel  in  N_TERM  abort the session (level, sampled each cycle)
core_done  in  1  core registered a vote (one-cycle pulse)
core_kind  in  2  vote kind valid with core_done: 1 = candidate, 3 = null
grant  out  N_TERM  one-hot owner of the core; 0 when idle
busy  out  1  session in progress
core_reset  out  1  one-cycle pulse clearing the core at session start/abort
core_valid  out  1  one-cycle key strobe to core
core_digit  out  4  digit qualified by core_valid
core_confirm  out  1  confirm flag qualified by core_valid
digit_count  out  3  digits forwarded in current session (0..4)
session_done  out  1  one-cycle pulse: vote registered
session_abort  out  1  one-cycle pulse: session aborted
abort_cause  out  1  valid with session_abort: 0 = cancel, 1 = timeout
last_term  out  3  index of terminal whose session last ended
last_kind  out  2  core_kind latched at last session_done

Behaviour:
- Reset: every output 0; state IDLE; rr_ptr 0; timeout counter 0. Reset mid-session drops grant on the next edge with no done/abort pulse.
- All outputs are registered. Pulses last exactly one cycle.
- States: IDLE, START, COLLECT, CONFIRM, WAIT_CORE.
- IDLE, on any req bit:
  - Select the first requesting index at or above rr_ptr, wrapping.
  - Set grant one-hot and busy=1; set rr_ptr = (sel+1) mod N_TERM. Go to START.
- START: core_reset=1 for this cycle, digit_count=0, load counter = TIMEOUT_CYCLES-1. Go to COLLECT.
- Accepted strobe: term_valid[g]=1 for the granted index g. Strobes from other terminals are ignored in every state.
- COLLECT, accepted strobe with term_confirm[g]=0:
  - Next cycle: core_valid=1, core_digit=term_digit[g], core_confirm=0.
  - digit_count increments and the counter reloads.
  - On the 4th digit, go to CONFIRM.
  - A confirm strobe in COLLECT is ignored and does not reload the counter.
- CONFIRM:
  - Accepted strobe with term_confirm[g]=1: next cycle core_valid=1, core_confirm=1, core_digit=0; counter reloads; go to WAIT_CORE.
  - Digit strobes are ignored.
- WAIT_CORE, on core_done:
  - session_done=1; last_kind=core_kind; last_term=g.
  - grant=0, busy=0, digit_count=0. Go to IDLE.
  - core_done in any other state is ignored.
- Timeout: in COLLECT, CONFIRM and WAIT_CORE the counter decrements each cycle. Abort when it is 0 and no accepted strobe occurs that cycle. Abort therefore fires TIMEOUT_CYCLES cycles after the last accepted event.
- Cancel: term_cancel[g]=1 in START, COLLECT, CONFIRM or WAIT_CORE aborts.
- Abort, next cycle:
  - session_abort=1 with abort_cause set; core_reset=1; last_term=g.
  - grant=0, busy=0, digit_count=0. Go to IDLE.
- Priority within one cycle: reset > cancel > core_done > accepted strobe > timeout.
- A new grant needs at least one IDLE cycle after a session ends.
- req deasserting during a session has no effect; the grant is held until done or abort.
- Cancel from non-granted terminals is ignored.

Test Plan:
- Single session: req=0001; terminal 0 keys 3,5,0,3 then confirm; core_done with kind=1 -> grant=0001 → core_reset pulse; 4 core_valid pulses carrying digits 3,5,0,3; confirm pulse with core_confirm=1; session_done=1, last_term=0, last_kind=1, grant=0.
- Round-robin: req=1111 held for three sessions from reset -> grants 0001, 0010, 0100 in order; each new grant follows at least one IDLE cycle.
- Isolation: terminal 2 strobes digits while terminal 1 holds the grant -> no core_valid; digit_count unchanged.
- Timeout: TIMEOUT_CYCLES=20; grant, 2 digits, then silence -> session_abort with abort_cause=1 exactly 20 cycles after the 2nd accepted strobe; core_reset pulse; busy=0.
- Cancel with simultaneous strobe: term_cancel[g] and term_valid[g] in the same cycle while in CONFIRM -> session_abort with cause 0; no core_valid.
- Reset mid-COLLECT after 3 digits -> next edge all outputs 0, no session pulses; the next grant goes to index 0 (rr_ptr cleared).

Source files
------------

// File: rtl/ballot_session_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ballot_session_arbiter_if                                     |
// | Purpose  : Bundles the terminal-side and core-side signals of the ballot |
// |            session arbiter.                                              |
// |            slave  : seen by the arbiter (terminal/core inputs in,        |
// |                     grant, core strobes and session status out)          |
// |            master : seen by the terminals/core environment               |
// | Ports    : req, term_valid, term_digit, term_confirm, term_cancel,       |
// |            core_done, core_kind -> arbiter                               |
// |            grant, busy, core_reset, core_valid, core_digit, core_confirm,|
// |            digit_count, session_done, session_abort, abort_cause,        |
// |            last_term, last_kind <- arbiter                               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface ballot_session_arbiter_if #(
  parameter int N_TERM = 4
);
  logic [N_TERM-1:0]   req;
  logic [N_TERM-1:0]   term_valid;
  logic [4*N_TERM-1:0] term_digit;
  logic [N_TERM-1:0]   term_confirm;
  logic [N_TERM-1:0]   term_cancel;
  logic                core_done;
  logic [1:0]          core_kind;

  logic [N_TERM-1:0]   grant;
  logic                busy;
  logic                core_reset;
  logic                core_valid;
  logic [3:0]          core_digit;
  logic                core_confirm;
  logic [2:0]          digit_count;
  logic                session_done;
  logic                session_abort;
  logic                abort_cause;
  logic [2:0]          last_term;
  logic [1:0]          last_kind;

  modport slave (
    input  req, term_valid, term_digit, term_confirm, term_cancel,
           core_done, core_kind,
    output grant, busy, core_reset, core_valid, core_digit, core_confirm,
           digit_count, session_done, session_abort, abort_cause,
           last_term, last_kind
  );

  modport master (
    output req, term_valid, term_digit, term_confirm, term_cancel,
           core_done, core_kind,
    input  grant, busy, core_reset, core_valid, core_digit, core_confirm,
           digit_count, session_done, session_abort, abort_cause,
           last_term, last_kind
  );
endinterface
`default_nettype wire

// File: rtl/ballot_session_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ballot_session_arbiter                                        |
// | Purpose  : Round-robin arbiter granting one keypad terminal at a time a  |
// |            full voting session (4 digits + confirm) on a shared ballot   |
// |            entry core, with inactivity timeout, cancel and outcome       |
// |            reporting. All outputs are registered.                        |
// | Ports    : clock - system clock                                          |
// |            reset - synchronous, active-high                              |
// |            bus   - ballot_session_arbiter_if.slave (terminal requests,   |
// |                    key strobes, core handshake, session status)          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ballot_session_arbiter #(
  parameter int N_TERM         = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TW             = 16
) (
  input wire clock,
  input wire reset,
  ballot_session_arbiter_if.slave bus
);

  localparam logic [TW-1:0]     c_TO_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [N_TERM-1:0] c_ONE     = N_TERM'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_COLLECT   = 3'd2,
    S_CONFIRM   = 3'd3,
    S_WAIT_CORE = 3'd4
  } state_t;

  state_t              r_state;
  logic [N_TERM-1:0]   r_grant;
  logic [2:0]          r_gidx;
  logic [2:0]          r_rr_ptr;
  logic [TW-1:0]       r_cnt;
  logic                r_busy;
  logic                r_core_reset;
  logic                r_core_valid;
  logic [3:0]          r_core_digit;
  logic                r_core_confirm;
  logic [2:0]          r_digit_count;
  logic                r_session_done;
  logic                r_session_abort;
  logic                r_abort_cause;
  logic [2:0]          r_last_term;
  logic [1:0]          r_last_kind;

  // Round-robin pick: rotate the request vector so rr_ptr sits at bit 0,
  // take the lowest set bit, then add rr_ptr back modulo N_TERM.
  logic [2*N_TERM-1:0] w_req_rot;
  logic [2:0]          w_off;
  logic [3:0]          w_sum;
  logic [2:0]          w_sel;
  logic                w_any;

  always_comb begin
    w_req_rot = {bus.req, bus.req} >> r_rr_ptr;
    w_off     = 3'd0;
    for (int k = N_TERM - 1; k >= 0; k--) begin
      if (w_req_rot[k]) w_off = 3'(k);
    end
    w_any = |bus.req;
    w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
    w_sel = (w_sum >= 4'(N_TERM)) ? 3'(w_sum - 4'(N_TERM)) : w_sum[2:0];
  end

  // Granted terminal's signals, selected through the one-hot grant.
  logic       w_strobe;
  logic       w_conf;
  logic       w_cancel;
  logic [3:0] w_digit;

  always_comb begin
    w_strobe = |(bus.term_valid   & r_grant);
    w_conf   = |(bus.term_confirm & r_grant);
    w_cancel = |(bus.term_cancel  & r_grant);
    w_digit  = 4'd0;
    for (int i = 0; i < N_TERM; i++) begin
      if (r_grant[i]) w_digit = w_digit | bus.term_digit[4*i +: 4];
    end
  end

  // Per-cycle decisions in priority order: cancel > core_done > strobe > timeout.
  // Only strobes that the current state acts upon count as events; an ignored
  // key neither reloads the counter nor holds off the timeout.
  logic w_active;
  logic w_do_cancel;
  logic w_do_done;
  logic w_event;
  logic w_do_timeout;

  always_comb begin
    w_active     = (r_state == S_COLLECT) || (r_state == S_CONFIRM) ||
                   (r_state == S_WAIT_CORE);
    w_do_cancel  = w_cancel && (w_active || (r_state == S_START));
    w_do_done    = !w_do_cancel && (r_state == S_WAIT_CORE) && bus.core_done;
    w_event      = !w_do_cancel && w_strobe &&
                   (((r_state == S_COLLECT) && !w_conf) ||
                    ((r_state == S_CONFIRM) && w_conf));
    w_do_timeout = w_active && !w_do_cancel && !w_do_done && !w_event &&
                   (r_cnt == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_grant         <= '0;
      r_gidx          <= 3'd0;
      r_rr_ptr        <= 3'd0;
      r_cnt           <= '0;
      r_busy          <= 1'b0;
      r_core_reset    <= 1'b0;
      r_core_valid    <= 1'b0;
      r_core_digit    <= 4'd0;
      r_core_confirm  <= 1'b0;
      r_digit_count   <= 3'd0;
      r_session_done  <= 1'b0;
      r_session_abort <= 1'b0;
      r_abort_cause   <= 1'b0;
      r_last_term     <= 3'd0;
      r_last_kind     <= 2'd0;
    end else begin
      r_core_reset    <= 1'b0;
      r_core_valid    <= 1'b0;
      r_core_digit    <= 4'd0;
      r_core_confirm  <= 1'b0;
      r_session_done  <= 1'b0;
      r_session_abort <= 1'b0;
      r_abort_cause   <= 1'b0;

      if (w_do_cancel || w_do_timeout) begin
        r_session_abort <= 1'b1;
        r_abort_cause   <= w_do_timeout;
        r_core_reset    <= 1'b1;
        r_last_term     <= r_gidx;
        r_grant         <= '0;
        r_busy          <= 1'b0;
        r_digit_count   <= 3'd0;
        r_cnt           <= '0;
        r_state         <= S_IDLE;
      end else if (w_do_done) begin
        r_session_done  <= 1'b1;
        r_last_kind     <= bus.core_kind;
        r_last_term     <= r_gidx;
        r_grant         <= '0;
        r_busy          <= 1'b0;
        r_digit_count   <= 3'd0;
        r_cnt           <= '0;
        r_state         <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_any) begin
              r_grant      <= c_ONE << w_sel;
              r_gidx       <= w_sel;
              r_busy       <= 1'b1;
              r_rr_ptr     <= (w_sel == 3'(N_TERM - 1)) ? 3'd0 : w_sel + 3'd1;
              // Core clear is visible during the START cycle.
              r_core_reset <= 1'b1;
              r_state      <= S_START;
            end
          end
          S_START: begin
            r_digit_count <= 3'd0;
            r_cnt         <= c_TO_LOAD;
            r_state       <= S_COLLECT;
          end
          S_COLLECT, S_CONFIRM, S_WAIT_CORE: begin
            if (w_event) begin
              r_cnt        <= c_TO_LOAD;
              r_core_valid <= 1'b1;
              if (r_state == S_COLLECT) begin
                r_core_digit  <= w_digit;
                r_digit_count <= r_digit_count + 3'd1;
                if (r_digit_count == 3'd3) r_state <= S_CONFIRM;
              end else begin
                r_core_confirm <= 1'b1;
                r_state        <= S_WAIT_CORE;
              end
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.grant         = r_grant;
  assign bus.busy          = r_busy;
  assign bus.core_reset    = r_core_reset;
  assign bus.core_valid    = r_core_valid;
  assign bus.core_digit    = r_core_digit;
  assign bus.core_confirm  = r_core_confirm;
  assign bus.digit_count   = r_digit_count;
  assign bus.session_done  = r_session_done;
  assign bus.session_abort = r_session_abort;
  assign bus.abort_cause   = r_abort_cause;
  assign bus.last_term     = r_last_term;
  assign bus.last_kind     = r_last_kind;

endmodule
`default_nettype wire
